// File: rtl/id_stage_fifo_if.sv
// id_stage_fifo_if: valid/ready handshake bundle carrying one decoded entry between decode stages.
interface id_stage_fifo_if #(
   parameter int WIDTH     = 32,
   parameter int ADR_WIDTH = 32,
   parameter int PAYLOAD_W = 64
);
   logic                 valid;
   logic                 ready;
   logic [WIDTH-1:0]     pc;
   logic [PAYLOAD_W-1:0] payload;
   logic [ADR_WIDTH-1:0] pred_adr;
   logic                 branch_jump;
   modport master (output valid, pc, payload, pred_adr, branch_jump, input ready);
   modport slave (input valid, pc, payload, pred_adr, branch_jump, output ready);
endinterface

// File: rtl/id_stage_fifo.sv
// id_stage_fifo: elastic decode-stage buffer with flush; define ID_FIFO_BYPASS_EN for an empty-buffer in->out bypass.
module id_stage_fifo #(
   parameter int WIDTH     = 32,
   parameter int ADR_WIDTH = 32,
   parameter int PAYLOAD_W = 64,
   parameter int DEPTH     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   id_stage_fifo_if.slave               up,
   id_stage_fifo_if.master              down,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = WIDTH + PAYLOAD_W + ADR_WIDTH + 1;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          empty, full, byp, push, pop, wr_en, rd_en;
   assign empty = count == '0;
   assign full  = count == CW'(DEPTH);
`ifdef ID_FIFO_BYPASS_EN
   assign byp = empty & !flush;
`else
   assign byp = 1'b0;
`endif
   assign head = mem[rd_ptr];
   assign up.ready   = rst_n & !full;
   assign down.valid = byp ? up.valid & up.ready : !empty & !flush;
   assign {down.pc, down.payload, down.pred_adr, down.branch_jump} =
      byp ? {up.pc, up.payload, up.pred_adr, up.branch_jump} : head;
   assign push  = up.valid & up.ready & !flush;
   assign pop   = down.valid & down.ready;
   // a bypassed entry consumed straight away never touches storage
   assign wr_en = push & !(byp & down.ready);
   assign rd_en = pop & !empty;
   always_ff @(posedge clk)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= {up.pc, up.payload, up.pred_adr, up.branch_jump};
endmodule

// File: tb/tb_id_stage_fifo.sv
// tb_id_stage_fifo: scoreboard bench for id_stage_fifo at DEPTH=4, default or ID_FIFO_BYPASS_EN build.
module tb_id_stage_fifo;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  count;
   int          tests = 0;
   int          errors = 0;
   logic [31:0] sb [$];
   id_stage_fifo_if #(.WIDTH(32), .ADR_WIDTH(32), .PAYLOAD_W(64)) up_if ();
   id_stage_fifo_if #(.WIDTH(32), .ADR_WIDTH(32), .PAYLOAD_W(64)) dn_if ();
   id_stage_fifo #(.WIDTH(32), .ADR_WIDTH(32), .PAYLOAD_W(64), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .up(up_if), .down(dn_if), .count(count)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] pl(input logic [31:0] p);
      return {p ^ 32'h5A5A_F00F, ~p};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // drive one cycle, compare against the queue model, then advance the model at the edge
   task automatic step(input logic v, input logic [31:0] p, input logic r, input logic f);
      logic        ev, rdy, push, pop, byp;
      logic [31:0] ep;
      @(negedge clk);
      up_if.valid = v;
      up_if.pc = p;
      up_if.payload = pl(p);
      up_if.pred_adr = p + 32'd4;
      up_if.branch_jump = p[2];
      dn_if.ready = r;
      flush = f;
      #1;
      rdy = sb.size() != DEPTH;
`ifdef ID_FIFO_BYPASS_EN
      byp = sb.size() == 0 && !f;
`else
      byp = 1'b0;
`endif
      ev = byp ? v : (sb.size() != 0 && !f);
      ep = byp ? p : (sb.size() != 0 ? sb[0] : 32'h0);
      check("in_ready", 64'(up_if.ready), 64'(rdy));
      check("out_valid", 64'(dn_if.valid), 64'(ev));
      check("count", 64'(count), 64'(sb.size()));
      if (ev) begin
         check("out_pc", 64'(dn_if.pc), 64'(ep));
         check("out_payload", dn_if.payload, pl(ep));
         check("out_pred_adr", 64'(dn_if.pred_adr), 64'(ep + 32'd4));
         check("out_branch_jump", 64'(dn_if.branch_jump), 64'(ep[2]));
      end
      push = v && rdy && !f;
      pop = ev && r;
      @(posedge clk);
      if (f) sb.delete();
      else begin
         if (push) sb.push_back(p);
         if (pop) void'(sb.pop_front());
      end
   endtask
   initial begin
      up_if.valid = 1'b0;
      up_if.pc = '0;
      up_if.payload = '0;
      up_if.pred_adr = '0;
      up_if.branch_jump = 1'b0;
      dn_if.ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(dn_if.valid), 64'd0);
      check("rst_in_ready", 64'(up_if.ready), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 64'(up_if.ready), 64'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step(1'b1, 32'h110, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      step(1'b1, 32'h340, 1'b1, 1'b0);
      step(1'b1, 32'h340, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      step(1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h600, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h200, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 29) == 0));
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
